req_serializer: RTL
===================

Name: req_serializer

Overview:
Parallel-to-serial stage that feeds the single-bit req input of the downstream seq_det (110 detector).
- Accepts WIDTH-bit words over a valid/ready handshake.
- Emits one bit per clock on req, qualified by req_valid.
- Drives req to 0 when idle, so idle cycles look like 0 bits to the detector.
- Pulses done once per completed word.

Parameters:
- WIDTH, 8, word width in bits; legal range WIDTH >= 2.
- MSB_FIRST, 1, 1 = bit WIDTH-1 sent first; 0 = bit 0 sent first.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data holds a word to send.
- in_data  input  WIDTH  parallel word.
- in_ready  output  1  block can accept a word this cycle.
- req  output  1  serial bit, registered; to seq_det.req.
- req_valid  output  1  req carries a word bit this cycle, registered.
- busy  output  1  state == SHIFT.
- done  output  1  one-cycle pulse: last bit of a word has been sent, registered.

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk.
- Reset values:
  - state = IDLE; req = 0, req_valid = 0, done = 0.
  - Shift register = 0; bit counter cnt = 0.
- States: IDLE, SHIFT. A handshake occurs on an edge where in_valid && in_ready.
- in_ready is combinational:
  - Default: in_ready = (state == IDLE).
  - With the optional feature enabled: in_ready also = 1 in SHIFT when cnt == 0.
- IDLE + handshake:
  - Load the word.
  - req <= first bit; req_valid <= 1.
  - cnt <= WIDTH-1; go to SHIFT.
- IDLE without handshake: req = 0, req_valid = 0; stay in IDLE.
- SHIFT, cnt != 0: shift; req <= next bit; cnt <= cnt-1.
- SHIFT, cnt == 0, no handshake:
  - req <= 0; req_valid <= 0; done <= 1; go to IDLE.
- Timing:
  - First bit is visible the cycle after the accept edge.
  - req_valid stays high for exactly WIDTH consecutive cycles.
  - done is high during the first cycle after the last bit.
- done is 0 in every cycle other than those above.
- cnt width is $clog2(WIDTH); no wrap beyond 0.
- While in_ready = 0, in_valid and in_data are ignored and nothing is captured. The source holds the word until it is accepted.
- Reset mid-word:
  - The word is abandoned; no done pulse.
  - req and req_valid are 0 in the next cycle; in_ready = 1 in the cycle after reset deasserts.
- in_data may change freely after the accept edge.

Optional Feature:
REQ_SERIALIZER_BACK2BACK_EN
- Defined:
  - in_ready is also high in the last-bit cycle (SHIFT, cnt == 0).
  - A handshake on that edge loads the new word; req <= its first bit; req_valid stays 1; cnt <= WIDTH-1; state stays SHIFT.
  - done still pulses for the completed word, coincident with the first bit of the new word.
  - Consecutive words form a gap-free bit stream.
- Undefined:
  - in_ready = (state == IDLE) only.
  - Consecutive words are separated by at least one idle cycle (req = 0, req_valid = 0).

Decomposition:
- Shared package seq_pkg:
  - State typedef (IDLE, SHIFT), 1-bit encoding.
  - Constant REQ_IDLE_BIT = 1'b0.
  - The seq_det state constants also move into seq_pkg.
- No sub-module: the shift register and down-counter are small enough to live inline.

Test Plan:
- Basic send: WIDTH=8, MSB_FIRST=1, in_data=8'b1101_0000, in_valid one cycle in IDLE -> req = 1,1,0,1,0,0,0,0 on cycles 1–8, req_valid high for those cycles, done=1 on cycle 9, in_ready=1 on cycle 9; seq_det fed the same stream sees one 110 match.
- LSB first: MSB_FIRST=0, in_data=8'h03 -> req = 1,1,0,0,0,0,0,0.
- Back-to-back, macro undefined: 8'hFF then 8'hAA with in_valid held -> req_valid low for exactly one cycle between words, req=0 in that cycle, done pulses twice.
- Back-to-back, macro defined: same stimulus -> req_valid high for 16 contiguous cycles, req = 1×8 then 1,0,1,0,1,0,1,0; done pulses in cycle 9 and cycle 17.
- Backpressure: in_valid raised during cycle 3 of a word with new data 8'h0F -> in_ready=0, not captured; accepted on the first in_ready cycle; sent intact.
- Reset mid-word: assert rst after 3 bits of 8'hFF -> next cycle req=0, req_valid=0, done=0; in_ready=1 after rst drops; a new word 8'h80 sends correctly.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the req_serializer -> seq_det (110 detector) serial path.
package seq_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

  // Idle cycles present a 0 bit to the detector.
  localparam logic REQ_IDLE_BIT = 1'b0;

  // seq_det states: nothing seen, "1" seen, "11" seen.
  localparam logic [1:0] DET_S0  = 2'd0;
  localparam logic [1:0] DET_S1  = 2'd1;
  localparam logic [1:0] DET_S11 = 2'd2;

endpackage

// File: rtl/req_serializer.sv
// Parallel-to-serial word feeder for seq_det.req; one bit per clock, done pulse per word.
// Optional macro REQ_SERIALIZER_BACK2BACK_EN: accept the next word in the last-bit cycle.
module req_serializer
  import seq_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             req,
  output logic             req_valid,
  output logic             busy,
  output logic             done
);

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  ser_state_e       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             req_q, req_d;
  logic             req_valid_q, req_valid_d;
  logic             done_q, done_d;
  logic             hs;
  logic [WIDTH-1:0] shifted;

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

`ifdef REQ_SERIALIZER_BACK2BACK_EN
  assign in_ready = (state_q == IDLE) || ((state_q == SHIFT) && (cnt_q == '0));
`else
  assign in_ready = (state_q == IDLE);
`endif

  assign hs        = in_valid && in_ready;
  assign shifted   = shift_word(shreg_q);
  assign req       = req_q;
  assign req_valid = req_valid_q;
  assign done      = done_q;
  assign busy      = (state_q == SHIFT);

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    req_d       = REQ_IDLE_BIT;
    req_valid_d = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (hs) begin
          shreg_d     = in_data;
          req_d       = first_bit(in_data);
          req_valid_d = 1'b1;
          cnt_d       = CNT_LAST;
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q != '0) begin
          shreg_d     = shifted;
          req_d       = first_bit(shifted);
          req_valid_d = 1'b1;
          cnt_d       = cnt_q - CNT_ONE;
        end else begin
          // Word complete; a handshake here only happens in back-to-back builds.
          done_d = 1'b1;
          if (hs) begin
            shreg_d     = in_data;
            req_d       = first_bit(in_data);
            req_valid_d = 1'b1;
            cnt_d       = CNT_LAST;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      req_q       <= REQ_IDLE_BIT;
      req_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      req_valid_q <= req_valid_d;
      done_q      <= done_d;
    end
  end

endmodule
